// File: rtl/ula_arb_pkg.sv
// Shared constants for the two-port ALU arbiter: data width, ALU op codes
// and the controller state encoding.
package ula_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/ula_arb_ula.sv
// Purely combinational 8-bit ALU; the single instance is shared by both
// arbiter ports.
module ula_arb_ula
    import ula_arb_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves o_result unassigned (no latch).
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_ADD:  o_result = i_a + i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_SUB:  o_result = i_a + ~i_b + DATA_W'(1);
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            default: o_result = '0;  // 100 and 101 are reserved and return zero
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/ula_arb.sv
// Two-port front end for one shared ALU: grants one request at a time,
// executes it for one cycle and holds the response until it is consumed.
module ula_arb
    import ula_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic              busy
);

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_gnt;
    logic              r_ptr;

    logic              w_idle;
    logic              w_resp;
    logic              w_gnt;
    logic              w_accept;
    logic              w_rsp_ready;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_zero;

    assign w_idle = (r_state == ST_IDLE);
    assign w_resp = (r_state == ST_RESP);

    // A lone requester always wins; contention goes to the pointer or to port 0.
    assign w_gnt = (req0_valid && req1_valid) ? (FAIR ? r_ptr : 1'b0) : req1_valid;

    assign req0_ready  = w_idle & req0_valid & ~w_gnt;
    assign req1_ready  = w_idle & req1_valid &  w_gnt;
    assign w_accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_rsp_ready = r_gnt ? rsp1_ready : rsp0_ready;

    ula_arb_ula u_ula (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_gnt    <= 1'b0;
            r_ptr    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_gnt ? req1_op : req0_op;
                        r_a     <= w_gnt ? req1_a  : req0_a;
                        r_b     <= w_gnt ? req1_b  : req0_b;
                        r_gnt   <= w_gnt;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_alu_result;
                    r_zero   <= w_alu_zero;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= ST_IDLE;
                        if (FAIR) r_ptr <= ~r_gnt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid  = w_resp & ~r_gnt;
    assign rsp1_valid  = w_resp &  r_gnt;
    assign rsp0_result = rsp0_valid ? r_result : '0;
    assign rsp1_result = rsp1_valid ? r_result : '0;
    assign rsp0_zero   = rsp0_valid & r_zero;
    assign rsp1_zero   = rsp1_valid & r_zero;
    assign busy        = ~w_idle;

endmodule

// File: doc/ula_arb.md
ULA_ARB -- requirements
Module: ula_arb

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-002 One clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 reqK_valid  input  1  port K (K=0,1) presents an operation.
REQ-006 reqK_ready  output  1  port K operation accepted this cycle.
REQ-007 reqK_op  input  3  ALU op code: 000 AND, 001 OR, 010 ADD, 011 NOR, 110 SUB, 111 SLT (unsigned).
REQ-008 reqK_a, reqK_b  input  8 each  operands A and B.
REQ-009 rspK_valid  output  1  port K result available.
REQ-010 rspK_ready  input  1  port K consumes the result.
REQ-011 rspK_result  output  8  ALU result for port K.
REQ-012 rspK_zero  output  1  1 when rspK_result == 8'h00.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-015 In IDLE, when at least one reqK_valid is high, the block SHALL assert reqK_ready for exactly one granted port, combinationally, in the same cycle.
REQ-016 A handshake is reqK_valid && reqK_ready; on it the block SHALL register op, a, b and grant id, and move to EXEC.
REQ-017 reqK_ready SHALL be 0 in EXEC and RESP; no second operation is in flight.
REQ-018 In EXEC the block SHALL drive the shared ALU from the registered operands, register result and zero flag, and move to RESP after exactly one cycle.
REQ-019 In RESP, rspK_valid SHALL be high only for the granted port, holding result and zero stable until rspK_ready is sampled high; it then moves to IDLE.
REQ-020 Latency: handshake at edge N gives rspK_valid high from edge N+2; minimum period between accepts is 3 cycles.
REQ-021 Arithmetic SHALL be 8-bit modulo 2^8: ADD and SUB wrap with no carry/overflow output; SUB is A + ~B + 1; SLT yields 8'h01 if A < B unsigned, else 8'h00.
REQ-022 Op codes 100 and 101 SHALL yield result 8'h00 and zero 1, returned through the normal response path.
REQ-023 FAIR=1: a pointer SHALL favour the port it names when both are valid; after each completed response it SHALL point to the port not just served.
REQ-024 FAIR=0: port 0 SHALL win every simultaneous request.
REQ-025 With only one port valid, that port SHALL be granted regardless of pointer.
REQ-026 rspK_result and rspK_zero for the non-granted port SHALL be 0.

Reset
REQ-027 On rst_n low: state IDLE; all ready/valid outputs 0; busy 0; result, zero, operand registers 0; round-robin pointer favours port 0.
REQ-028 Reset during EXEC or RESP SHALL abandon the operation; no response is ever issued for it.

Structure
REQ-029 Package ula_arb_pkg SHALL hold the op-code constants and the state encoding.
REQ-030 The ALU SHALL be one instantiated sub-module, ULA, shared by both ports; no second ALU.

Verification
REQ-031 Port 0 ADD a=8'h05 b=8'h03 at edge N, rsp0_ready=1 -> rsp0_valid at N+2, result 8'h08, zero 0.
REQ-032 Port 1 SUB a=8'h10 b=8'h10 -> result 8'h00, zero 1; then ADD 8'hFF+8'h02 -> 8'h01 (wrap).
REQ-033 FAIR=1, both ports valid continuously after reset -> grants alternate 0,1,0,1; FAIR=0 same stimulus -> port 0 every time.
REQ-034 Port 0 SLT 8'h02,8'h07 with rsp0_ready low 3 cycles -> rsp0_valid and result 8'h01 held stable, req1_ready stays 0 despite req1_valid=1.
REQ-035 Op 3'b100 -> result 8'h00, zero 1; rst_n pulsed low during EXEC -> no rsp0_valid afterwards, busy 0.
